// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the instruction/data memory bus arbiter.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ACK
    } arb_state_t;

    typedef enum logic {
        OWN_INSTR,
        OWN_DATA
    } owner_t;

    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mem_bus_arbiter_watchdog.sv
// Stall counter that flags a bus cycle stuck in wait states for LIMIT cycles.
module bus_watchdog #(
    parameter int unsigned LIMIT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic timeout_o
);

    localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The stall that brings the count to LIMIT is the one that fires
    generate
        if (LIMIT == 0) begin : g_off
            assign timeout_o = 1'b0;
        end else begin : g_on
            assign timeout_o = en_i && (cnt_q == CW'(LIMIT - 1));
        end
    endgenerate

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one Avalon-style memory master between instruction fetch and data access.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_byteenable,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        bus_error
);

    arb_state_t  state_q, state_d;
    owner_t      owner_q, owner_d;
    owner_t      last_q, last_d;
    owner_t      grant;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] irdata_q, irdata_d;
    logic [31:0] drdata_q, drdata_d;
    logic [3:0]  be_q, be_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        err_q, err_d;
    logic        d_req;
    logic        timeout;

    assign d_req = d_read | d_write;

    // On a tie the bus goes to whoever was not served last
    always_comb begin
        if (i_req && d_req) begin
            grant = (last_q == OWN_INSTR) ? OWN_DATA : OWN_INSTR;
        end else if (d_req) begin
            grant = OWN_DATA;
        end else begin
            grant = OWN_INSTR;
        end
    end

    bus_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk      (clk),
        .rst      (reset),
        .clr_i    (state_q == IDLE),
        .en_i     ((state_q == BUSY) && avm_waitrequest),
        .timeout_o(timeout)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        irdata_d = irdata_q;
        drdata_d = drdata_q;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    state_d = BUSY;
                    owner_d = grant;
                    if (grant == OWN_DATA) begin
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        be_d    = d_byteenable;
                        wr_d    = d_write;
                        rd_d    = d_read & ~d_write;
                        if (d_read && d_write) begin
                            err_d = 1'b1;
                        end
                    end else begin
                        addr_d  = i_addr;
                        wdata_d = '0;
                        be_d    = BE_WORD;
                        wr_d    = 1'b0;
                        rd_d    = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (!avm_waitrequest) begin
                    state_d = ACK;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    last_d  = owner_q;
                    if (owner_q == OWN_INSTR) begin
                        irdata_d = avm_readdata;
                    end else if (!wr_q) begin
                        drdata_d = avm_readdata;
                    end
                end else if (timeout) begin
                    state_d = ACK;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    last_d  = owner_q;
                    err_d   = 1'b1;
                    if (owner_q == OWN_INSTR) begin
                        irdata_d = '0;
                    end else begin
                        drdata_d = '0;
                    end
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= OWN_INSTR;
            last_q   <= OWN_INSTR;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            irdata_q <= '0;
            drdata_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
            err_q    <= err_d;
        end
    end

    assign i_ack          = (state_q == ACK) && (owner_q == OWN_INSTR);
    assign d_ack          = (state_q == ACK) && (owner_q == OWN_DATA);
    assign i_rdata        = irdata_q;
    assign d_rdata        = drdata_q;
    assign avm_address    = addr_q;
    assign avm_read       = rd_q;
    assign avm_write      = wr_q;
    assign avm_writedata  = wdata_q;
    assign avm_byteenable = be_q;
    assign bus_error      = err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomised transaction-level check of mem_bus_arbiter against a reference model.
module tb_mem_bus_arbiter;
    import mem_bus_pkg::*;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_byteenable;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        bus_error;

    mem_bus_arbiter #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_req          (i_req),
        .i_addr         (i_addr),
        .i_ack          (i_ack),
        .i_rdata        (i_rdata),
        .d_read         (d_read),
        .d_write        (d_write),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_byteenable   (d_byteenable),
        .d_ack          (d_ack),
        .d_rdata        (d_rdata),
        .avm_address    (avm_address),
        .avm_read       (avm_read),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_byteenable (avm_byteenable),
        .avm_waitrequest(avm_waitrequest),
        .avm_readdata   (avm_readdata),
        .bus_error      (bus_error)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: who was served last, expected read words, error flag
    owner_t      last_m;
    logic [31:0] ird_m;
    logic [31:0] drd_m;
    logic        err_m;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        last_m = OWN_INSTR;
        ird_m  = '0;
        drd_m  = '0;
        err_m  = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_flags"}, 32'({avm_byteenable, avm_read, avm_write,
                                  i_ack, d_ack, bus_error}), 32'd0);
        chk({tag, "_addr"}, avm_address, 32'd0);
        chk({tag, "_wdata"}, avm_writedata, 32'd0);
        chk({tag, "_irdata"}, i_rdata, 32'd0);
        chk({tag, "_drdata"}, d_rdata, 32'd0);
    endtask

    // Called at the negedge of the request cycle with the owner's inputs driven.
    task automatic phase(input owner_t own, input int waits, input bit drop);
        logic [31:0] e_addr, e_wd, rd_last;
        logic [3:0]  e_be;
        logic        e_rd, e_wr;
        bit          tmo;
        int          strobe_n, ack_k;
        if (own == OWN_INSTR) begin
            e_addr = i_addr; e_wd = '0; e_be = 4'hF;
            e_rd = 1'b1; e_wr = 1'b0;
        end else begin
            e_addr = d_addr; e_wd = d_wdata; e_be = d_byteenable;
            e_wr = d_write; e_rd = d_read && !d_write;
            if (d_read && d_write) err_m = 1'b1;
        end
        tmo = (TO != 0) && (waits >= TO);
        strobe_n = tmo ? TO : waits + 1;
        ack_k = strobe_n + 1;
        rd_last = '0;
        for (int k = 1; k <= ack_k; k++) begin
            @(negedge clk);
            if (k <= strobe_n) begin
                chk("avm_read", 32'(avm_read), 32'(e_rd));
                chk("avm_write", 32'(avm_write), 32'(e_wr));
                chk("avm_address", avm_address, e_addr);
                chk("avm_byteenable", 32'(avm_byteenable), 32'(e_be));
                if (own == OWN_INSTR || e_wr)
                    chk("avm_writedata", avm_writedata, e_wd);
            end else begin
                chk("strobe_drop", 32'({avm_read, avm_write}), 32'd0);
            end
            if (k < ack_k) begin
                chk("early_ack", 32'({i_ack, d_ack}), 32'd0);
            end else begin
                if (own == OWN_INSTR) begin
                    ird_m = tmo ? 32'd0 : rd_last;
                    chk("i_ack", 32'({i_ack, d_ack}), 32'b10);
                    i_req = 1'b0;
                end else begin
                    if (tmo) drd_m = 32'd0;
                    else if (!e_wr) drd_m = rd_last;
                    chk("d_ack", 32'({i_ack, d_ack}), 32'b01);
                    d_read = 1'b0;
                    d_write = 1'b0;
                end
                if (tmo) err_m = 1'b1;
                last_m = own;
                chk("i_rdata", i_rdata, ird_m);
                chk("d_rdata", d_rdata, drd_m);
                chk("bus_error", 32'(bus_error), 32'(err_m));
            end
            if (k == 1 && drop) begin
                // Withdraw and scramble after the grant; the cycle must not notice
                if (own == OWN_INSTR) i_req = 1'b0;
                else begin d_read = 1'b0; d_write = 1'b0; end
                i_addr = $urandom;
                d_addr = $urandom;
                d_wdata = $urandom;
                d_byteenable = 4'($urandom);
            end
            avm_waitrequest = (k <= waits);
            avm_readdata = $urandom;
            if (k == waits + 1) rd_last = avm_readdata;
        end
    endtask

    // kind: 0 fetch, 1 data read, 2 data write, 3 read+write together
    task automatic xfer(input int kind, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be,
                        input int waits, input bit drop);
        @(negedge clk);
        chk("idle_strobe", 32'({avm_read, avm_write, i_ack, d_ack}), 32'd0);
        if (kind == 0) begin
            i_req = 1'b1;
            i_addr = addr;
        end else begin
            d_addr = addr;
            d_wdata = wd;
            d_byteenable = be;
            d_read = (kind == 1) || (kind == 3);
            d_write = (kind == 2) || (kind == 3);
        end
        phase(kind == 0 ? OWN_INSTR : OWN_DATA, waits, drop);
    endtask

    task automatic tie(input int w1, input int w2);
        owner_t first;
        @(negedge clk);
        i_req = 1'b1;
        i_addr = $urandom;
        d_addr = $urandom;
        d_wdata = $urandom;
        d_byteenable = 4'($urandom);
        d_write = 1'($urandom);
        d_read = ~d_write;
        first = (last_m == OWN_INSTR) ? OWN_DATA : OWN_INSTR;
        phase(first, w1, 1'b0);
        @(negedge clk);
        phase(first == OWN_INSTR ? OWN_DATA : OWN_INSTR, w2, 1'b0);
    endtask

    initial begin
        int r, w;
        reset = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_read = 1'b0; d_write = 1'b0;
        d_addr = '0; d_wdata = '0; d_byteenable = '0;
        avm_waitrequest = 1'b0; avm_readdata = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;

        xfer(0, 32'hBFC00000, 32'd0, 4'h0, 0, 1'b0);
        model_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tie(0, 1);
        tie(2, 0);
        xfer(2, 32'h00001000, 32'hDEADBEEF, 4'b0011, 3, 1'b0);
        xfer(1, 32'h00002004, 32'd0, 4'b1100, TO + 4, 1'b0);
        xfer(0, 32'h00000040, 32'd0, 4'h0, TO, 1'b0);
        xfer(1, 32'h00000080, 32'd0, 4'hF, TO - 1, 1'b0);

        @(negedge clk);
        d_addr = 32'h00003000; d_read = 1'b1;
        @(negedge clk);
        avm_waitrequest = 1'b1;
        @(negedge clk);
        chk("busy_before_reset", 32'(avm_read), 32'd1);
        #2 reset = 1'b1;
        #1 chk_all_zero("async_reset");
        d_read = 1'b0;
        model_reset();
        @(negedge clk);
        chk("no_ack_in_reset", 32'({i_ack, d_ack}), 32'd0);
        reset = 1'b0;
        xfer(1, 32'h00003000, 32'd0, 4'hF, 0, 1'b0);
        xfer(3, 32'h00004000, 32'h12345678, 4'hF, 1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            w = ($urandom_range(0, 7) == 0) ? $urandom_range(TO, TO + 2)
                                            : $urandom_range(0, 3);
            if (r >= 7)
                tie($urandom_range(0, 3), $urandom_range(0, 3));
            else
                xfer(r < 2 ? 0 : r < 4 ? 1 : r < 6 ? 2 : 3, $urandom,
                     $urandom, 4'($urandom), w, 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
